// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter : iterative RISC-V M-extension multiply/divide unit.
//
// Handles one operand bit per clock: radix-2 shift-add multiply and restoring
// divide. Signed operations work on magnitudes and fix the sign in a single
// FIX cycle at the end. Divide-by-zero and signed overflow are recognised when
// the operation is accepted and complete without iterating.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid_i/mdu_op_i/a_i/b_i until ready_o is seen.
// valid_o/result_o stay stable until ready_i. ready_o and valid_o are pure
// decodes of the state register, with no combinational path from valid_i or
// ready_i.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   valid_i   operation request valid
//   ready_o   unit idle and able to accept (state == IDLE)
//   mdu_op_i  funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a_i       rs1 (multiplicand / dividend)
//   b_i       rs2 (multiplier / divisor)
//   flush_i   synchronous abort; blocks accept while idle
//   valid_o   result_o holds a finished result (state == DONE)
//   ready_i   consumer takes the result
//   result_o  XLEN-bit result
// -----------------------------------------------------------------------------
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      mdu_op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state;
   logic [2:0]          r_op;
   logic                r_a_neg;
   logic                r_b_neg;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*XLEN-1:0]   r_acc;     // product accumulator
   logic [XLEN:0]       r_rem;     // partial remainder, one extra bit for trial subtract
   logic [XLEN-1:0]     r_x;       // multiplier (shifts right) / dividend->quotient (shifts left)
   logic [XLEN-1:0]     r_y;       // multiplicand / divisor, fixed during CALC
   logic [XLEN-1:0]     r_result;

   assign ready_o  = (r_state == S_IDLE);
   assign valid_o  = (r_state == S_DONE);
   assign result_o = r_result;

   // ---------------------------------------------------------------- accept
   logic            w_accept;
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div_zero;
   logic            w_div_ovf;
   logic [XLEN-1:0] w_special_res;

   assign w_accept   = valid_i & (r_state == S_IDLE) & ~flush_i;
   assign w_a_signed = (mdu_op_i == OP_MULH) | (mdu_op_i == OP_MULHSU) |
                       (mdu_op_i == OP_DIV)  | (mdu_op_i == OP_REM);
   assign w_b_signed = (mdu_op_i == OP_MULH) | (mdu_op_i == OP_DIV) |
                       (mdu_op_i == OP_REM);
   assign w_a_neg    = w_a_signed & a_i[XLEN-1];
   assign w_b_neg    = w_b_signed & b_i[XLEN-1];
   // Negating the most negative value yields itself, which is the correct
   // unsigned magnitude.
   assign w_a_mag    = w_a_neg ? (~a_i + 1'b1) : a_i;
   assign w_b_mag    = w_b_neg ? (~b_i + 1'b1) : b_i;
   assign w_div_zero = mdu_op_i[2] & (b_i == '0);
   assign w_div_ovf  = ((mdu_op_i == OP_DIV) | (mdu_op_i == OP_REM)) &
                       (a_i == MOST_NEG) & (b_i == '1);

   always_comb begin
      w_special_res = '0;
      if (w_div_zero) begin
         w_special_res = mdu_op_i[1] ? a_i : '1;     // REM/REMU : DIV/DIVU
      end else if (w_div_ovf) begin
         w_special_res = mdu_op_i[1] ? '0 : a_i;
      end
   end

   // ------------------------------------------------------------- iteration
   logic [XLEN-1:0] w_addend;
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_trial;
   logic [XLEN:0]   w_diff;
   logic            w_fits;

   assign w_addend = r_x[0] ? r_y : '0;
   assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
   assign w_trial  = {r_rem[XLEN-1:0], r_x[XLEN-1]};
   assign w_diff   = w_trial - {1'b0, r_y};
   // Top bit clear means the trial subtraction did not borrow.
   assign w_fits   = ~w_diff[XLEN];

   // ------------------------------------------------------------ sign fixup
   logic              w_neg_res;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rmd;
   logic [XLEN-1:0]   w_fix_res;

   // Unsigned variants captured both signs as 0, so one flag serves all ops.
   assign w_neg_res = r_a_neg ^ r_b_neg;
   assign w_prod    = w_neg_res ? (~r_acc + 1'b1) : r_acc;
   assign w_quo     = w_neg_res ? (~r_x + 1'b1) : r_x;
   assign w_rmd     = r_a_neg ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix_res = w_quo;
         OP_REM, OP_REMU:              w_fix_res = w_rmd;
         default:                      w_fix_res = '0;
      endcase
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_a_neg  <= 1'b0;
         r_b_neg  <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= mdu_op_i;
                  r_a_neg <= w_a_neg;
                  r_b_neg <= w_b_neg;
                  r_cnt   <= CNT_W'(XLEN-1);
                  r_acc   <= '0;
                  r_rem   <= '0;
                  if (mdu_op_i[2]) begin
                     r_x <= w_a_mag;
                     r_y <= w_b_mag;
                  end else begin
                     r_x <= w_b_mag;
                     r_y <= w_a_mag;
                  end
                  if (w_div_zero | w_div_ovf) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end

            S_CALC: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  if (r_op[2]) begin
                     r_rem <= w_fits ? w_diff : w_trial;
                     r_x   <= {r_x[XLEN-2:0], w_fits};
                  end else begin
                     // Sum lands in the top half; product bits shift down.
                     r_acc <= {w_sum, r_acc[XLEN-1:1]};
                     r_x   <= {1'b0, r_x[XLEN-1:1]};
                  end
                  if (r_cnt == '0) begin
                     r_state <= S_FIX;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end

            S_FIX: begin
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_result <= w_fix_res;
                  r_state  <= S_DONE;
               end
            end

            S_DONE: begin
               if (flush_i || ready_i) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// Bench for mdu_iter (XLEN=32): directed cases, randomized operations against
// a 64-bit arithmetic reference, output hold, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mdu_iter;
   localparam int XLEN = 32;
   localparam int NORMAL_LAT = XLEN + 2;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      mdu_op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] exp_q[$];

   mdu_iter #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .mdu_op_i (mdu_op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .flush_i  (flush_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o)
   );

   // ------------------------------------------------------ clock / reset
   always #5 clk = ~clk;

   // ---------------------------------------------------- reference model
   function automatic logic [31:0] ref_model(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub, p, q;
      logic [63:0] r;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (op)
         3'd0: begin r = ua * ub; return r[31:0]; end
         3'd1: begin p = sa * sb; r = p; return r[63:32]; end
         3'd2: begin p = sa * ub; r = p; return r[63:32]; end
         3'd3: begin r = ua * ub; return r[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = sa / sb; r = q; return r[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = ua / ub; r = q; return r[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            q = sa % sb; r = q; return r[31:0];
         end
         default: begin
            if (b == 0) return a;
            q = ua % ub; r = q; return r[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 1;
      return NORMAL_LAT;
   endfunction

   // ---------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------ drivers
   // All driving and sampling happens just after a falling edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      check($sformatf("ready_before_op%0d", op), {31'b0, ready_o}, 1);
      mdu_op_i = op;
      a_i      = a;
      b_i      = b;
      valid_i  = 1'b1;
      exp_q.push_back(ref_model(op, a, b));
      @(negedge clk);
      valid_i  = 1'b0;
      // Scramble operands: the unit must not re-sample them.
      a_i      = $urandom;
      b_i      = $urandom;
      mdu_op_i = 3'($urandom_range(0, 7));
   endtask

   // Returns the cycle index (accept cycle = 0) at which valid_o is seen.
   task automatic wait_result(output int lat);
      lat = 1;
      while (valid_o !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      int          lat;
      logic [31:0] e;
      issue(op, a, b);
      wait_result(lat);
      check($sformatf("valid_seen op%0d a=%h b=%h", op, a, b), {31'b0, valid_o}, 1);
      check($sformatf("latency op%0d a=%h b=%h", op, a, b), lat, ref_latency(op, a, b));
      e = exp_q.pop_front();
      check($sformatf("result op%0d a=%h b=%h", op, a, b), result_o, e);
      @(negedge clk);
      check("valid_one_cycle", {31'b0, valid_o}, 0);
      check("ready_after_handshake", {31'b0, ready_o}, 1);
   endtask

   task automatic expect_no_valid(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b0) seen++;
      end
      check(tag, seen, 0);
   endtask

   // ----------------------------------------------------------- stimulus
   initial begin
      int          lat;
      logic [31:0] e;
      logic [31:0] held;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;

      rst_ni   = 1'b0;
      valid_i  = 1'b0;
      mdu_op_i = '0;
      a_i      = '0;
      b_i      = '0;
      flush_i  = 1'b0;
      ready_i  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ready", {31'b0, ready_o}, 1);
      check("reset_valid", {31'b0, valid_o}, 0);
      check("reset_result", result_o, 0);
      rst_ni = 1'b1;
      @(negedge clk);

      // Directed arithmetic
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd5, 32'd100, 32'd7);
      run_op(3'd7, 32'd100, 32'd7);
      // Special cases
      run_op(3'd5, 32'd5, 32'd0);
      run_op(3'd6, 32'd5, 32'd0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // Output held while the consumer stalls
      ready_i = 1'b0;
      issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_result(lat);
      check("hold_latency", lat, NORMAL_LAT);
      e = exp_q.pop_front();
      check("hold_result", result_o, e);
      held = result_o;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold_valid_%0d", i), {31'b0, valid_o}, 1);
         check($sformatf("hold_ready_%0d", i), {31'b0, ready_o}, 0);
         check($sformatf("hold_stable_%0d", i), result_o, e);
      end
      ready_i = 1'b1;
      @(negedge clk);
      check("release_ready", {31'b0, ready_o}, 1);
      check("release_valid", {31'b0, valid_o}, 0);
      check("release_result_kept", result_o, held);
      run_op(3'd4, 32'hFFFF_FC18, 32'd3);

      // Flush while idle blocks the accept
      flush_i  = 1'b1;
      valid_i  = 1'b1;
      mdu_op_i = 3'd0;
      a_i      = 32'd9;
      b_i      = 32'd9;
      @(negedge clk);
      flush_i = 1'b0;
      valid_i = 1'b0;
      check("idle_flush_no_accept", {31'b0, ready_o}, 1);
      expect_no_valid("idle_flush_no_valid", 3);

      // Flush in the middle of CALC
      issue(3'd0, 32'hDEAD_BEEF, 32'h0000_1234);
      void'(exp_q.pop_front());
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_ready", {31'b0, ready_o}, 1);
      check("flush_valid", {31'b0, valid_o}, 0);
      expect_no_valid("flush_no_valid", 40);
      run_op(3'd0, 32'd3, 32'd4);

      // Asynchronous reset in the middle of CALC
      issue(3'd5, 32'hFFFF_0000, 32'd13);
      void'(exp_q.pop_front());
      repeat (6) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_ready", {31'b0, ready_o}, 1);
      check("async_rst_valid", {31'b0, valid_o}, 0);
      check("async_rst_result", result_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      expect_no_valid("rst_no_valid", 40);
      run_op(3'd0, 32'd3, 32'd4);

      // Randomized operations, biased towards boundary operands
      for (int n = 0; n < 40; n++) begin
         op  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         run_op(op, a, b);
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time guard so the run always terminates.
   initial begin
      #500000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit; the next-generation arithmetic block beside the single-cycle integer ALU. It adds the RISC-V M-extension operations.
- Processes one operand bit per cycle (radix-2 shift-add multiply, restoring divide).
- Uses valid/ready handshakes on both input and output, so the core can stall on it.
- Sits in the execute stage; the core's decoder drives `mdu_op_i` directly with funct3.

Parameters:
- XLEN, 32: operand and result width; any value ≥ 4.
- CNT_W, $clog2(XLEN): width of the bit-iteration counter (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operands and op are valid.
- ready_o  out  1  unit can accept an operation.
- mdu_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  XLEN  rs1 operand (multiplicand/dividend).
- b_i  in  XLEN  rs2 operand (multiplier/divisor).
- flush_i  in  1  synchronous abort of the current operation.
- valid_o  out  1  result_o holds a finished result.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (async, rst_ni=0): state IDLE, ready_o=1, valid_o=0, result_o=0, and all internal registers cleared. Reset asserted mid-operation discards that operation.
- ready_o = (state==IDLE). valid_o = (state==DONE). Both outputs are registered-state decodes, with no combinational path from valid_i or ready_i.
- Accept happens at an edge where valid_i & ready_o. At the accept edge:
  - Capture op and operand signs.
  - Capture magnitudes: |a| for MULH, MULHSU, DIV, REM; |b| for MULH, DIV, REM; all other operands are taken as raw unsigned.
  - Load the counter with XLEN-1 and clear the 2*XLEN accumulator/remainder.
- Special cases, detected at the accept edge, go IDLE→DONE directly; valid_o is high in the cycle after the accept edge.
  - b_i==0 on a divide op: DIV/DIVU result is all-ones; REM/REMU result is a_i.
  - Signed overflow (DIV/REM with a_i = most negative value, b_i = all-ones): DIV result is a_i; REM result is 0.
- Otherwise IDLE→CALC. CALC performs one iteration per edge:
  - Multiply: conditional add plus shift.
  - Divide: shift remainder, trial subtract, set quotient bit.
  - When the counter reaches 0, go CALC→FIX. CALC lasts exactly XLEN edges.
- FIX (one edge):
  - Negate the product if the operand signs differ (MUL, MULH, MULHSU only).
  - Negate the quotient if the signs differ (DIV).
  - Give the remainder the dividend's sign (REM).
  - Select the low half (MUL) or high half (MULH*). Register into result_o, then go FIX→DONE.
- Normal latency: valid_o rises XLEN+2 cycles after the accept cycle, i.e. in the cycle after the (XLEN+1)th edge following the accept edge.
- DONE holds result_o and valid_o stable until ready_i=1. The handshake edge goes DONE→IDLE and clears valid_o. result_o keeps its value until the next FIX or special-case load.
- No accept is possible in the handshake cycle (ready_o=0 in DONE). Minimum issue interval is XLEN+3 cycles with ready_i tied high.
- flush_i=1 at any edge in CALC, FIX or DONE → IDLE; valid_o is not asserted afterwards.
- flush_i in IDLE blocks the accept in that cycle. flush_i has priority over the output handshake.
- valid_i, a_i and b_i are ignored outside IDLE. Operands are not re-sampled during CALC.
- All arithmetic is modulo 2^XLEN for results. The internal accumulator is 2*XLEN wide; the divide remainder register is XLEN+1 wide for the trial subtract.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD, ready_i=1 → result_o=0xFFFFFFEB; valid_o high exactly 34 cycles after the accept cycle, for one cycle.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. In all four, valid_o is high in the cycle after the accept cycle.
- Hold ready_i=0 for 5 cycles after valid_o rises → result_o and valid_o stable, ready_o=0. Raising ready_i → IDLE next edge and ready_o=1; a new op accepted next cycle gives the correct result.
- Assert flush_i at CALC iteration 10, and separately drop rst_ni asynchronously mid-CALC → IDLE, valid_o never asserts, ready_o=1. The following MUL 3×4 returns 12.
